hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard/stall controller for the 5-stage pipeline; it produces the stall1/stall2 qualifiers that forwarding consumes.
//  Tracks bubble occupancy of ID/EX/MEM, detects load-use hazards, kills wrong-path instrs on taken branch,
//  freezes the pipe while the data memory is not ready, and halts on a memory timeout.
//  Sits beside forwarding in the top-level CPU; all hold/flush/bubble outputs act in the same cycle.
// PARAMETERS
//  MEM_TIMEOUT  64  max consecutive mem-wait cycles before entering ERR (>=2)
//  CNT_W        32  width of stall_cnt performance counter
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      synchronous reset, active-high
//  id_rs1          in   5      rs1 address of instr in ID
//  id_rs2          in   5      rs2 address of instr in ID
//  id_use_rs1      in   1      ID instr actually reads rs1
//  id_use_rs2      in   1      ID instr actually reads rs2
//  ex_rd           in   5      destination reg of instr in EX
//  ex_is_load      in   1      instr in EX is a load
//  ex_branch_taken in   1      instr in EX resolved a taken branch/jump
//  mem_req         in   1      instr in MEM issues a data-memory access
//  mem_ready       in   1      data memory completes access this cycle
//  pc_hold         out  1      PC keeps value
//  ifid_hold       out  1      IF/ID register keeps value
//  ifid_flush      out  1      IF/ID loads NOP
//  idex_bubble     out  1      ID/EX loads NOP
//  pipe_freeze     out  1      all pipeline registers (incl. EX/MEM, MEM/WB) hold
//  stall1          out  1      EX stage holds a bubble (ex_bub)
//  stall2          out  1      MEM stage holds a bubble (mem_bub)
//  mem_timeout     out  1      sticky: memory wait exceeded MEM_TIMEOUT
//  stall_cnt       out  CNT_W  saturating count of cycles with pc_hold=1
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, id_bub=ex_bub=mem_bub=1, mem_timeout=0, stall_cnt=0.
//   While rst=1: pc_hold/ifid_hold/ifid_flush/idex_bubble/pipe_freeze=0; stall1=stall2=1.
//  Bubble regs (stall1=ex_bub, stall2=mem_bub): update only when freeze=0:
//   id_bub<=ifid_flush; ex_bub<=idex_bubble|id_bub; mem_bub<=ex_bub. When freeze=1: hold.
//  freeze = (state==RUN & mem_req & !mem_ready & !mem_bub) | (state==WAIT & !mem_ready) | (state==ERR).
//  load_use = !ex_bub & ex_is_load & ex_rd!=0 & !id_bub &
//             ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  Priority each cycle (combinational, rst=0):
//   1 freeze:          pc_hold=ifid_hold=pipe_freeze=1; ifid_flush=idex_bubble=0; branch/load_use ignored.
//   2 ex_branch_taken & !ex_bub: ifid_flush=idex_bubble=1, pc_hold=ifid_hold=0 (load_use suppressed).
//   3 load_use:        pc_hold=ifid_hold=idex_bubble=1, ifid_flush=0. Exactly one bubble per load.
//   4 else all 0.
//  FSM:
//   RUN : mem_req&!mem_ready&!mem_bub -> WAIT, wait_cnt<=1; else stay, wait_cnt<=0.
//   WAIT: mem_ready -> RUN, wait_cnt<=0; else if wait_cnt==MEM_TIMEOUT-1 -> ERR, mem_timeout<=1;
//         else wait_cnt<=wait_cnt+1.
//   ERR : absorbing until rst; pipe_freeze=1 permanently.
//  Freeze releases in the same cycle mem_ready=1; branch held in EX during freeze acts after release.
//  stall_cnt: +1 per cycle pc_hold=1, saturates at all-ones, never wraps.
//  rst mid-WAIT/ERR: returns to RUN next edge, all regs to reset values.
// TESTING
//  T1 reset release, 3 cycles no hazards -> stall1=1,1,1 then 0s as NOPs drain; controls all 0.
//  T2 ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> 1 cycle pc_hold=ifid_hold=idex_bubble=1; next cycle stall1=1, stall_cnt=1.
//  T3 load_use and ex_branch_taken same cycle -> ifid_flush=idex_bubble=1, pc_hold=0; next id_bub=1, ex_bub=1.
//  T4 mem_req=1, mem_ready low 3 cycles then high -> pipe_freeze=1 for 3 cycles, 0 on 4th; stall1/2 unchanged.
//  T5 MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after 4th wait cycle, freeze stays 1 until rst; rst clears.
//  T6 ex_rd=0 load with id_rs1=0 -> no stall; ex_bub=1 with matching rd -> no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard/stall controller for the 5-stage pipeline. It tracks
//            bubble occupancy of ID/EX/MEM, inserts one bubble per load-use
//            hazard, kills wrong-path instructions on a taken branch, freezes
//            the pipe while data memory is busy, and halts on a memory
//            timeout.
// Ports    : clk, rst                 clock / synchronous active-high reset
//            id_rs1, id_rs2           source regs of the ID instruction
//            id_use_rs1, id_use_rs2   ID instruction really reads rs1/rs2
//            ex_rd, ex_is_load        destination / load flag of EX instr
//            ex_branch_taken          EX instruction redirects the PC
//            mem_req, mem_ready       MEM-stage data access handshake
//            pc_hold, ifid_hold       front-end hold controls
//            ifid_flush, idex_bubble  NOP injection controls
//            pipe_freeze              every pipeline register holds
//            stall1, stall2           EX / MEM stage holds a bubble
//            mem_timeout              sticky memory-timeout flag
//            stall_cnt                saturating count of pc_hold cycles
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             stall1,
  output logic             stall2,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic                id_bub_q, ex_bub_q, mem_bub_q;
  logic [CNT_W-1:0]    stall_cnt_q;

  logic                freeze;
  logic                load_use;
  logic                mem_stall_start;

  // A bubble in MEM cannot be waiting on memory, whatever mem_req says.
  assign mem_stall_start = mem_req & ~mem_ready & ~mem_bub_q;

  assign freeze = ((state_q == ST_RUN)  & mem_stall_start) |
                  ((state_q == ST_WAIT) & ~mem_ready)      |
                  (state_q == ST_ERR);

  assign load_use = ~ex_bub_q & ex_is_load & (ex_rd != 5'd0) & ~id_bub_q &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

  // Memory-wait state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall_start) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
          state_d   = ST_ERR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  // Same-cycle pipeline controls; freeze dominates, then branch, then load-use.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        pipe_freeze = 1'b1;
      end else if (ex_branch_taken && !ex_bub_q) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  // Bubble occupancy follows the pipeline and holds with it during a freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_bub_q  <= 1'b1;
      ex_bub_q  <= 1'b1;
      mem_bub_q <= 1'b1;
    end else if (!freeze) begin
      id_bub_q  <= ifid_flush;
      ex_bub_q  <= idex_bubble | id_bub_q;
      mem_bub_q <= ex_bub_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pc_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // While in reset the downstream stages must already see bubbles.
  assign stall1      = rst | ex_bub_q;
  assign stall2      = rst | mem_bub_q;
  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4,
//            CNT_W=4 so counter saturation is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;
  logic       mem_req, mem_ready;
  logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze;
  logic       stall1, stall2, mem_timeout;
  logic [3:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .stall1(stall1), .stall2(stall2),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Advance to the next cycle's falling edge; inputs are then driven and
  // outputs sampled #1 later, well away from the rising edge.
  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_hit_rs1();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    next_cyc(); #1;
    // reset values
    check("rst_pc_hold", pc_hold, 1'b0);
    check("rst_freeze", pipe_freeze, 1'b0);
    check("rst_stall1", stall1, 1'b1);
    check("rst_stall2", stall2, 1'b1);
    check("rst_cnt", stall_cnt, 4'd0);
    check("rst_timeout", mem_timeout, 1'b0);

    // T1: reset release, NOPs drain (id,ex,mem = 1,1,1)
    next_cyc(); rst = 1'b0; #1;
    check("t1_c0_stall1", stall1, 1'b1);
    check("t1_c0_ctrl", {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze}, 5'b0);
    next_cyc(); #1;
    check("t1_c1_stall1", stall1, 1'b1);
    next_cyc(); #1;
    check("t1_c2_stall1", stall1, 1'b0);
    check("t1_c2_stall2", stall2, 1'b1);
    next_cyc(); #1;
    check("t1_c3_stall2", stall2, 1'b0);

    // T2: single load-use bubble
    next_cyc(); load_hit_rs1(); #1;
    check("t2_ctrl", {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze}, 5'b11010);
    next_cyc(); #1;            // same inputs, EX now a bubble
    check("t2_stall1", stall1, 1'b1);
    check("t2_cnt", stall_cnt, 4'd1);
    check("t2_one_bubble", pc_hold, 1'b0);
    next_cyc(); idle(); #1;
    check("t2_drain_stall2", stall2, 1'b1);
    next_cyc(); #1;
    check("t2_drained", {stall1, stall2}, 2'b00);

    // T3: branch beats load-use
    next_cyc(); load_hit_rs1(); ex_branch_taken = 1'b1; #1;
    check("t3_ctrl", {pc_hold, ifid_hold, ifid_flush, idex_bubble}, 4'b0011);
    next_cyc(); idle(); ex_branch_taken = 1'b1; #1;   // branch in a bubble: ignored
    check("t3_c1_stall1", stall1, 1'b1);
    check("t3_bub_branch", ifid_flush, 1'b0);
    next_cyc(); idle(); #1;    // ex_bub still 1 because id_bub was 1
    check("t3_c2_stall", {stall1, stall2}, 2'b11);
    next_cyc(); #1;
    check("t3_c3_stall", {stall1, stall2}, 2'b01);
    check("t3_cnt", stall_cnt, 4'd1);
    next_cyc(); #1;

    // T4: 3 cycles of memory wait, branch held in EX acts after release
    next_cyc(); mem_req = 1'b1; ex_branch_taken = 1'b1; #1;
    check("t4_f1_ctrl", {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze}, 5'b11001);
    next_cyc(); #1;
    check("t4_f2_freeze", pipe_freeze, 1'b1);
    next_cyc(); #1;
    check("t4_f3_freeze", pipe_freeze, 1'b1);
    check("t4_f3_stall", {stall1, stall2}, 2'b00);
    next_cyc(); mem_ready = 1'b1; #1;
    check("t4_f4_ctrl", {pc_hold, ifid_flush, idex_bubble, pipe_freeze}, 4'b0110);
    check("t4_cnt", stall_cnt, 4'd4);
    next_cyc(); idle(); #1;
    check("t4_after_stall1", stall1, 1'b1);
    check("t4_after_freeze", pipe_freeze, 1'b0);
    for (int i = 0; i < 4; i++) next_cyc();

    // T5: timeout after 4 wait cycles, ERR sticks, counter saturates
    mem_req = 1'b1; #1;
    check("t5_g1_freeze", pipe_freeze, 1'b1);
    next_cyc(); next_cyc(); next_cyc(); #1;
    check("t5_g4_timeout", mem_timeout, 1'b0);
    next_cyc(); #1;
    check("t5_g5_timeout", mem_timeout, 1'b1);
    check("t5_g5_cnt", stall_cnt, 4'd8);
    next_cyc(); mem_req = 1'b0; mem_ready = 1'b1; #1;
    check("t5_err_freeze", pipe_freeze, 1'b1);
    for (int i = 0; i < 14; i++) next_cyc();
    #1;
    check("t5_cnt_sat", stall_cnt, 4'hF);
    check("t5_err_hold", pc_hold, 1'b1);
    next_cyc(); rst = 1'b1; #1;
    check("t5_rst_freeze", pipe_freeze, 1'b0);
    check("t5_rst_stall1", stall1, 1'b1);
    next_cyc(); rst = 1'b0; idle(); #1;
    check("t5_clr_timeout", mem_timeout, 1'b0);
    check("t5_clr_cnt", stall_cnt, 4'd0);
    check("t5_clr_freeze", pipe_freeze, 1'b0);

    // T6: non-hazards (bubbles right after reset)
    load_hit_rs1(); mem_req = 1'b1; #1;   // ex_bub=1, mem_bub=1
    check("t6_exbub_nostall", pc_hold, 1'b0);
    check("t6_membub_nofreeze", pipe_freeze, 1'b0);
    next_cyc(); load_hit_rs1(); #1;       // ex_bub still 1
    check("t6_exbub2_nostall", pc_hold, 1'b0);
    next_cyc(); idle(); ex_is_load = 1'b1; id_use_rs1 = 1'b1; #1;  // rd=rs1=0
    check("t6_x0_nostall", pc_hold, 1'b0);
    next_cyc(); load_hit_rs1(); id_use_rs1 = 1'b0; #1;
    check("t6_unused_nostall", pc_hold, 1'b0);
    next_cyc(); idle(); ex_is_load = 1'b1; ex_rd = 5'd9;
    id_rs2 = 5'd9; id_use_rs2 = 1'b1; #1;
    check("t6_rs2_stall", {pc_hold, idex_bubble}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
